// File: rtl/uart_tx_framer.sv
// UART transmit framer: turns rising edges of the divided baud clock into bit ticks and
// shifts out start, data, optional parity (UART_TX_PARITY_EN) and stop bits.
module uart_tx_framer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 frame_done,
  output logic [2:0]           state_o
);

  // Handshake: a byte transfers on any rising clk_in edge where tx_valid && tx_ready;
  // tx_data is only sampled on that edge and tx_ready stays low until the frame ends.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic [2:0]           state_q, state_d;
  logic                 baud_clk_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_serial_q, tx_serial_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 frame_done_q, frame_done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic tick, accept, data_last, stop_last;

  assign tick      = baud_clk & ~baud_clk_q;
  assign accept    = tx_valid & tx_ready_q;
  assign data_last = (bit_cnt_q == 3'(DATA_BITS - 1));
  assign stop_last = (stop_cnt_q == 1'(STOP_BITS - 1));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= S_IDLE;
      baud_clk_q   <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      tx_serial_q  <= 1'b1;
      tx_ready_q   <= 1'b1;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_clk_q   <= baud_clk;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      tx_serial_q  <= tx_serial_d;
      tx_ready_q   <= tx_ready_d;
      tx_busy_q    <= tx_busy_d;
      frame_done_q <= frame_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ARM;
      S_ARM:    if (tick) state_d = S_START;
      S_START:  if (tick) state_d = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (tick && data_last) state_d = S_PARITY;
      S_PARITY: if (tick) state_d = S_STOP;
`else
      S_DATA:   if (tick && data_last) state_d = S_STOP;
`endif
      S_STOP:   if (tick && stop_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The shift register moves right as each data bit is driven, so bit 0 is always next.
  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    tx_serial_d  = tx_serial_q;
    tx_ready_d   = tx_ready_q;
    tx_busy_d    = tx_busy_q;
    frame_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_serial_d = 1'b1;
        if (accept) begin
          shift_d    = tx_data;
          tx_ready_d = 1'b0;
          tx_busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^tx_data;
`endif
        end
      end
      S_ARM: if (tick) tx_serial_d = 1'b0;
      S_START: if (tick) begin
        tx_serial_d = shift_q[0];
        shift_d     = shift_q >> 1;
        bit_cnt_d   = '0;
      end
      S_DATA: if (tick) begin
        if (data_last) begin
`ifdef UART_TX_PARITY_EN
          tx_serial_d = parity_q;
`else
          tx_serial_d = 1'b1;
`endif
          stop_cnt_d  = 1'b0;
        end else begin
          tx_serial_d = shift_q[0];
          shift_d     = shift_q >> 1;
          bit_cnt_d   = bit_cnt_q + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (tick) begin
        tx_serial_d = 1'b1;
        stop_cnt_d  = 1'b0;
      end
`endif
      S_STOP: if (tick) begin
        if (stop_last) begin
          frame_done_d = 1'b1;
          tx_ready_d   = 1'b1;
          tx_busy_d    = 1'b0;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: tx_serial_d = 1'b1;
    endcase
  end

  assign tx_serial  = tx_serial_q;
  assign tx_ready   = tx_ready_q;
  assign tx_busy    = tx_busy_q;
  assign frame_done = frame_done_q;
  assign state_o    = state_q;

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

UART transmit framer that consumes the divided baud clock produced by the upstream clock divider and serialises bytes onto the TX line. It detects rising edges of the divided clock, treats each one as a single-cycle bit tick, and shifts out start, data, optional parity and stop bits. It accepts bytes through a valid/ready handshake from the processor-side data path.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal values 5–8.
- `STOP_BITS`, default 1: stop bits per frame, legal values 1 or 2.
- `clk_in` input, 1 bit: system clock; all logic is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `baud_clk` input, 1 bit: divided square wave from the clock divider, synchronous to `clk_in`.
- `tx_data` input, `DATA_BITS` bits: byte to send.
- `tx_valid` input, 1 bit: `tx_data` is valid.
- `tx_ready` output, 1 bit: framer can accept a byte.
- `tx_serial` output, 1 bit: UART line; idles high.
- `tx_busy` output, 1 bit: a frame is pending or in progress.
- `frame_done` output, 1 bit: one-cycle pulse when the last stop bit ends.

## Operation
- Bit tick: `tick = baud_clk & ~baud_clk_q`, where `baud_clk_q` is `baud_clk` registered on `clk_in`.
  - `baud_clk_q` resets to 1, so a line that is already high at reset produces no tick.
- Handshake: a byte is accepted in any cycle where `tx_valid && tx_ready`.
  - The byte is latched into the shift register.
  - The parity bit is computed from the latched byte.
  - `tx_ready` drops the next cycle.
  - `tx_data` is ignored after acceptance.
- States:
  - IDLE: `tx_ready=1`, `tx_serial=1`. Acceptance moves to ARM.
  - ARM: wait for a tick. On the tick, drive `tx_serial=0` and move to START.
  - START: on a tick, drive data bit 0 and move to DATA. Bit counter = 0.
  - DATA: on each tick, advance the counter and drive the next bit, LSB first.
    - After bit `DATA_BITS-1` has been held for one tick, move to PARITY if parity is enabled, otherwise to STOP and drive 1.
  - PARITY: hold the parity bit for one tick, then move to STOP and drive 1.
  - STOP: hold 1 for `STOP_BITS` ticks.
    - On the final tick, go to IDLE and pulse `frame_done`.
- Each bit is held for exactly one tick period. The frame is `1 + DATA_BITS + P + STOP_BITS` tick periods, where P = 1 with parity and 0 without.
- Ticks in IDLE are ignored.
- `tx_valid` while busy has no effect; no byte is lost, because `tx_ready` is 0.
- Reset mid-frame: the frame is abandoned.
  - The next cycle shows `tx_serial=1`, `tx_ready=1`, `tx_busy=0`, `frame_done=0`, state IDLE.
  - No `frame_done` is emitted for the aborted frame.

## Timing
- All outputs are registered.
- Reset values: `tx_serial=1`, `tx_ready=1`, `tx_busy=0`, `frame_done=0`.
- Acceptance at cycle N gives `tx_ready=0` and `tx_busy=1` at N+1.
- The start bit appears on `tx_serial` one cycle after the first tick following acceptance. All later bit transitions also lag their tick by one cycle.
- `frame_done` and `tx_ready=1` both appear one cycle after the final stop-bit tick. `tx_busy` falls in that same cycle.
- Back-to-back frames:
  - A byte accepted in the cycle `tx_ready` returns waits for the next tick to start.
  - The line stays high from the final stop tick until that start, giving no extra idle gap beyond tick alignment.
- A tick and an acceptance in the same cycle: the tick is not consumed by ARM. The start bit waits for the following tick.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - An even parity bit (XOR of all data bits) is sent between the last data bit and the stop bits.
- Not defined:
  - No PARITY state and no parity logic.
  - The frame goes directly from the last data bit to the stop bits.

## Test plan
- Reset, then idle with `baud_clk` toggling every 4 cycles, no `tx_valid`.
  - Expect `tx_serial=1`, `tx_ready=1`, `tx_busy=0` throughout.
- Send 0xA5 with no parity, 8N1, tick every 8 cycles.
  - Expect line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles.
  - Expect `frame_done` once, one cycle after the stop tick.
- With `UART_TX_PARITY_EN`, send 0x07.
  - Expect parity bit 1.
  - Expect 11 bit periods for 8 data bits and 1 stop bit.
- Hold `tx_valid` high with 0x3C then 0xC3, and `STOP_BITS=2`.
  - Expect both frames intact, each with two stop periods of 1.
  - Expect 0xC3 accepted in the cycle `tx_ready` reasserts.
- Assert `reset` for 1 cycle during data bit 3.
  - Expect the line high and `tx_ready=1` the next cycle, and no `frame_done`.
  - A new byte sent afterwards must be correct.
- Assert `tx_valid` in the same cycle as a tick.
  - Expect the start bit to be delayed to the next tick.
